// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode constants, FSM states and the IF/ID bundle.
// Decode imports the opcode slice and halt opcode from here.
package instr_fetch_unit_pkg;

  localparam int PC_WIDTH    = 5;
  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP     = 4;
  localparam int OPC_HI      = 31;
  localparam int OPC_LO      = 26;

  localparam logic [OPC_HI-OPC_LO:0] HALT_OPCODE = 6'b111110;

  typedef enum logic [1:0] {
    WAIT,
    RUN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic                   valid;
  } if_id_t;

  function automatic logic is_halt(
    input logic [INSTR_WIDTH-1:0] instr
  );
    return instr[OPC_HI:OPC_LO] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_sequencer.sv
// Program counter: hold, step with natural wrap, or aligned redirect.
// Redirect wins over advance.
module instr_fetch_unit_pc_sequencer
  import instr_fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_redirect,
  input  logic                i_advance,
  input  logic [PC_WIDTH-1:0] i_target,
  output logic [PC_WIDTH-1:0] o_pc
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_pc;
    if (i_redirect)
      w_next = i_target & ~PC_WIDTH'(3);
    else if (i_advance)
      w_next = r_pc + PC_WIDTH'(PC_STEP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_pc <= '0;
    else
      r_pc <= w_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: FSM, IF/ID register, halt detect and fetch counter.
// The PC itself lives in the pc_sequencer sub-module.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic                   if_id_valid,
  output logic                   halted,
  output logic [7:0]             fetch_count
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  if_id_t       r_if_id;
  logic [7:0]   r_count;

  logic w_redirect;
  logic w_advance;
  logic w_capture;
  logic w_flush;

  instr_fetch_unit_pc_sequencer u_pc_sequencer (
    .clk        (clk),
    .rst        (rst),
    .i_redirect (w_redirect),
    .i_advance  (w_advance),
    .i_target   (branch_target),
    .o_pc       (pc_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= WAIT;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_redirect   = 1'b0;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    w_flush      = 1'b0;
    unique case (r_state)
      WAIT: w_next_state = RUN;
      RUN: begin
        priority case (1'b1)
          branch_taken: begin
            w_redirect = 1'b1;
            w_flush    = 1'b1;
          end
          !stall: begin
            w_capture = 1'b1;
            if (is_halt(instr_in))
              w_next_state = HALTED;
            else
              w_advance = 1'b1;
          end
          default: ;
        endcase
      end
      // Halt word stays visible while decode is stalled
      HALTED: w_flush = !stall;
      default: w_next_state = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_id <= '0;
    end else if (w_capture) begin
      r_if_id.instr <= instr_in;
      r_if_id.pc    <= pc_out;
      r_if_id.valid <= 1'b1;
    end else if (w_flush) begin
      r_if_id.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_count <= '0;
    else if (w_capture && r_count != 8'hFF)
      r_count <= r_count + 8'd1;
  end

  assign if_id_instr = r_if_id.instr;
  assign if_id_pc    = r_if_id.pc;
  assign if_id_valid = r_if_id.valid;
  assign halted      = (r_state == HALTED);
  assign fetch_count = r_count;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage that drives the instruction memory's word-aligned byte address and consumes the 32-bit instruction it returns. It owns the program counter, sequences PC through the 32-byte instruction space, applies branch redirects and decode stalls, detects a halt opcode, and presents a registered IF/ID pipeline register to decode. It sits between the instruction memory (combinational read) and the decode stage.

## Interface
- HALT_OPCODE, 6'b111110: value of instr[31:26] that stops fetch
- PC_STEP, 4: PC increment per fetched instruction (bytes)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low; one clock domain
- stall  in  1  decode cannot accept; hold PC and IF/ID contents
- branch_taken  in  1  redirect PC this cycle; flush IF/ID
- branch_target  in  5  redirect byte address; bits [1:0] forced to 0
- instr_in  in  32  instruction from memory at pc_out, same cycle
- pc_out  out  5  current fetch address to memory
- if_id_instr  out  32  registered instruction to decode
- if_id_pc  out  5  registered address of if_id_instr
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch stopped on HALT_OPCODE
- fetch_count  out  8  instructions accepted into IF/ID, saturates at 255

## Operation
- FSM states: WAIT, RUN, HALTED. Reset enters WAIT.
- WAIT: one cycle after reset release (lets memory contents settle); pc_out=0, no capture; -> RUN.
- RUN, priority per cycle: branch_taken > stall > halt detect > normal advance.
  - branch_taken: PC <= {branch_target[4:2],2'b00}; if_id_valid <= 0; instruction at pc_out discarded; fetch_count unchanged. Applies even while stall=1.
  - stall (no branch): PC, if_id_* and fetch_count hold.
  - instr_in[31:26]==HALT_OPCODE: capture into IF/ID (valid=1), fetch_count+1, PC holds, -> HALTED.
  - normal: IF/ID <= {instr_in, pc_out, valid=1}; PC <= PC+PC_STEP, mod 32 (28 wraps to 0); fetch_count+1 (saturating).
- HALTED: halted=1; PC frozen; if_id_valid <= 0 on first cycle unless stall=1 (then holds until stall drops, so decode still receives the halt word); branch_taken ignored; exit only by reset.
- Reset (asserted any time, incl. mid-branch or mid-stall): immediately pc_out=0, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0, fetch_count=0, state=WAIT.

## Timing
- pc_out is a register output; memory read is combinational; instr_in sampled on the same rising edge that advances PC.
- Latency: address → IF/ID valid = 1 cycle. Steady state: one instruction per cycle.
- Branch penalty: 1 bubble (if_id_valid=0 for exactly one cycle after a taken branch with no stall).
- First valid IF/ID: second rising edge after reset release (WAIT + one fetch) — if_id_pc=0.
- stall is sampled at the edge; deassertion resumes on the next edge with no lost or duplicated instruction.

## Structure
- Shared package: PC_WIDTH=5, INSTR_WIDTH=32, PC_STEP, HALT_OPCODE default, FSM state enum (WAIT/RUN/HALTED), opcode field slice constants [31:26] — decode reuses these.
- One natural sub-module: pc_sequencer (PC register, increment/wrap, branch mux with alignment, hold); top holds FSM, IF/ID register, halt detect, fetch_count.

## Test plan
- Reset release, memory words 0x00000020 at 0,4,8: pc_out 0,0,4,8; if_id_pc 0,4 on cycles 2,3; fetch_count 1,2.
- Run from 0 with no branch and no halt opcode for 9 fetches: pc_out reaches 28 then 0; if_id_pc sequence 0..28,0; fetch_count=9.
- branch_taken with target 5'b10111 at pc_out=8: next pc_out=20; if_id_valid=0 one cycle; next if_id_pc=20; fetch_count unchanged on flush.
- stall high 3 cycles at pc_out=12: pc_out, if_id_instr, fetch_count constant; after release if_id_pc=12 then 16, no duplicate. Branch during stall: redirect taken.
- Word 0xF8000000 at 16: if_id_instr=0xF8000000 valid one cycle, halted=1, pc_out stays 16; branch_taken then ignored; rst low mid-halt clears all outputs asynchronously.
- Run 300 fetches without halt: fetch_count saturates at 255.
